// File: rtl/hilo_muldiv_sequencer.sv
// hilo_muldiv_sequencer
// Iterative multiply/divide unit that owns the HI/LO register pair.
// Each MULTU/DIVU runs one iteration per cycle. The pipeline is stalled while
// an operation is in flight and a HI/LO read or a new operation is requested.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   Start           request a new operation (held by requester while Stall)
//   IsDiv           1 = divide, 0 = multiply (sampled with Start)
//   IsSigned        signed request (only honoured with MULDIV_SIGNED_EN)
//   SrcA, SrcB      multiplicand/dividend and multiplier/divisor
//   LHRead          01 = read LO, 10 = read HI, 00/11 = none
//   Flush           abort an operation still in RUN/FIXUP
//   Busy            operation in flight
//   Stall           pipeline stall request
//   Done            one-cycle pulse in the cycle HI/LO are written
//   LHData          committed HI or LO selected by LHRead, else 0
//
// Build option: define MULDIV_SIGNED_EN to add signed MULT/DIV with a
// one-cycle FIXUP state for sign correction.

module hilo_muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic             IsDiv,
  input  logic             IsSigned,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [1:0]       LHRead,
  input  logic             Flush,
  output logic             Busy,
  output logic             Stall,
  output logic             Done,
  output logic [WIDTH-1:0] LHData
);

`ifdef MULDIV_SIGNED_EN
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIXUP = 2'd2, COMMIT = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, COMMIT = 2'd3} state_t;
`endif

  state_t state, next_state;

  logic [WIDTH-1:0] hi_q, lo_q;
  logic [WIDTH-1:0] acc_hi, acc_lo, opb;
  logic             op_div;
  logic [CNT_W-1:0] count;
  logic             accept, last_iter;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   mul_sum, div_rsh;
  logic [WIDTH-1:0] div_diff, step_hi, step_lo;
  logic             div_ge;

`ifdef MULDIV_SIGNED_EN
  logic               op_signed, sign_diff, sign_a;
  logic               neg_a, neg_b;
  logic [WIDTH-1:0]   fix_hi, fix_lo;
  logic [2*WIDTH-1:0] prod_neg;

  // The core always runs unsigned; signed operands enter as magnitudes.
  assign neg_a = IsSigned & SrcA[WIDTH-1];
  assign neg_b = IsSigned & SrcB[WIDTH-1];
  assign mag_a = neg_a ? -SrcA : SrcA;
  assign mag_b = neg_b ? -SrcB : SrcB;

  // Sign correction. A zero divisor keeps the all-ones quotient untouched so
  // the result matches the unsigned divide-by-zero behaviour (HI = SrcA).
  always_comb begin
    fix_hi   = acc_hi;
    fix_lo   = acc_lo;
    prod_neg = -{acc_hi, acc_lo};
    if (op_div) begin
      if (sign_a)                  fix_hi = -acc_hi;
      if (sign_diff && opb != '0)  fix_lo = -acc_lo;
    end else if (sign_diff) begin
      {fix_hi, fix_lo} = prod_neg;
    end
  end
`else
  logic unused_is_signed;
  assign unused_is_signed = IsSigned;
  assign mag_a = SrcA;
  assign mag_b = SrcB;
`endif

  assign last_iter = (count == CNT_W'(WIDTH - 1));

  // One shift-add or restoring-divide step. The divide remainder never
  // exceeds WIDTH bits after the step, so only the shifted-in compare needs
  // the extra bit.
  always_comb begin
    mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
    div_rsh  = {acc_hi, acc_lo[WIDTH-1]};
    div_ge   = (div_rsh >= {1'b0, opb});
    div_diff = div_rsh[WIDTH-1:0] - opb;
    if (op_div) begin
      step_hi = div_ge ? div_diff : div_rsh[WIDTH-1:0];
      step_lo = {acc_lo[WIDTH-2:0], div_ge};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next state and control outputs. Flush alongside Start in IDLE wins.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    Done       = 1'b0;
    case (state)
      IDLE: begin
        if (Start && !Flush) begin
          accept     = 1'b1;
          next_state = RUN;
        end
      end
      RUN: begin
        if (Flush) begin
          next_state = IDLE;
        end else if (last_iter) begin
`ifdef MULDIV_SIGNED_EN
          next_state = op_signed ? FIXUP : COMMIT;
`else
          next_state = COMMIT;
`endif
        end
      end
`ifdef MULDIV_SIGNED_EN
      FIXUP: next_state = Flush ? IDLE : COMMIT;
`endif
      COMMIT: begin
        Done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign Busy  = (state != IDLE);
  assign Stall = Busy & (Start | (LHRead == 2'b01) | (LHRead == 2'b10));

  // Working accumulator and the architectural HI/LO registers. HI/LO are
  // only ever written in COMMIT, so reads never see partial results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q   <= '0;
      lo_q   <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opb    <= '0;
      op_div <= 1'b0;
      count  <= '0;
`ifdef MULDIV_SIGNED_EN
      op_signed <= 1'b0;
      sign_diff <= 1'b0;
      sign_a    <= 1'b0;
`endif
    end else begin
      if (accept) begin
        acc_hi <= '0;
        acc_lo <= mag_a;
        opb    <= mag_b;
        op_div <= IsDiv;
        count  <= '0;
`ifdef MULDIV_SIGNED_EN
        op_signed <= IsSigned;
        sign_diff <= neg_a ^ neg_b;
        sign_a    <= neg_a;
`endif
      end else if (state == RUN && !Flush) begin
        acc_hi <= step_hi;
        acc_lo <= step_lo;
        count  <= count + 1'b1;
      end
`ifdef MULDIV_SIGNED_EN
      else if (state == FIXUP && !Flush) begin
        acc_hi <= fix_hi;
        acc_lo <= fix_lo;
      end
`endif
      if (state == COMMIT) begin
        hi_q <= acc_hi;
        lo_q <= acc_lo;
      end
    end
  end

  always_comb begin
    case (LHRead)
      2'b01:   LHData = lo_q;
      2'b10:   LHData = hi_q;
      default: LHData = '0;
    endcase
  end

endmodule

// File: tb/tb_hilo_muldiv_sequencer.sv
// tb_hilo_muldiv_sequencer
// Self-checking bench for hilo_muldiv_sequencer (WIDTH = 32). Expected HI/LO
// values come from plain 64-bit arithmetic; latencies come from the
// documented cycle counts. Signed cases are added when MULDIV_SIGNED_EN is
// defined for both bench and design.

module tb_hilo_muldiv_sequencer;

  localparam int W = 32;
`ifdef MULDIV_SIGNED_EN
  localparam bit signedBuild = 1'b1;
`else
  localparam bit signedBuild = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          Start, IsDiv, IsSigned, Flush;
  logic [W-1:0]  SrcA, SrcB;
  logic [1:0]    LHRead;
  logic          Busy, Stall, Done;
  logic [W-1:0]  LHData;

  int errors = 0;
  int checks = 0;

  hilo_muldiv_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .Start(Start), .IsDiv(IsDiv), .IsSigned(IsSigned),
    .SrcA(SrcA), .SrcB(SrcB), .LHRead(LHRead), .Flush(Flush),
    .Busy(Busy), .Stall(Stall), .Done(Done), .LHData(LHData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result {HI, LO} straight from the arithmetic definition.
  function automatic logic [63:0] refResult(input logic [31:0] a, input logic [31:0] b,
                                            input bit isDiv, input bit isSig);
    logic signed [63:0] sa, sb;
    logic [63:0] q, r;
    if (!signedBuild) isSig = 1'b0;
    if (isDiv && b == 32'h0) return {a, 32'hFFFF_FFFF};
    if (!isSig) begin
      if (isDiv) return {a % b, a / b};
      return {32'h0, a} * {32'h0, b};
    end
    sa = $signed({{32{a[31]}}, a});
    sb = $signed({{32{b[31]}}, b});
    if (isDiv) begin
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
    end
    return sa * sb;
  endfunction

  function automatic int refLatency(input bit isSig);
    return (signedBuild && isSig) ? W + 1 : W;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic start, input logic isDiv, input logic isSig,
                               input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [1:0] lhRead, input logic flush);
    Start    = start;
    IsDiv    = isDiv;
    IsSigned = isSig;
    SrcA     = a;
    SrcB     = b;
    LHRead   = lhRead;
    Flush    = flush;
  endtask

  // Read both halves plus the two "no read" encodings.
  task automatic checkHiLo(input string tag, input logic [W-1:0] expHi, input logic [W-1:0] expLo);
    LHRead = 2'b10; #1; checkOutput({tag, "_hi"}, LHData, expHi);
    LHRead = 2'b01; #1; checkOutput({tag, "_lo"}, LHData, expLo);
    LHRead = 2'b11; #1; checkOutput({tag, "_rd11"}, LHData, '0);
    LHRead = 2'b00; #1; checkOutput({tag, "_rd00"}, LHData, '0);
  endtask

  // Called just after the accept edge; waits for Done, checks latency,
  // then the committed HI/LO one edge later.
  task automatic finishOp(input string tag, input logic [63:0] expRes, input int expLat);
    int lat;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (Done !== 1'b1 && lat < 200);
    checkOutput({tag, "_done"}, Done, 1'b1);
    checkOutput({tag, "_latency"}, lat, expLat);
    tick();
    checkOutput({tag, "_idle"}, {Busy, Done}, 2'b00);
    checkHiLo(tag, expRes[63:32], expRes[31:0]);
  endtask

  task automatic runOp(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit isDiv, input bit isSig);
    applyStimulus(1'b1, isDiv, isSig, a, b, 2'b00, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 2'b00, 1'b0);
    checkOutput({tag, "_busy"}, Busy, 1'b1);
    finishOp(tag, refResult(a, b, isDiv, isSig), refLatency(isSig));
  endtask

  initial begin
    logic [W-1:0] a, b;
    bit           d, s;
    int           cnt, doneCount;
    logic [63:0]  expA, expB;

    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 2'b00, 1'b0);
    #1;
    checkOutput("reset_ctrl", {Busy, Stall, Done}, 3'b000);
    checkHiLo("reset", '0, '0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Directed corner values
    runOp("mul_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    checkHiLo("mul_max_const", 32'hFFFF_FFFE, 32'h0000_0001);
    runOp("div_100_7", 32'd100, 32'd7, 1'b1, 1'b0);
    checkHiLo("div_100_7_const", 32'd2, 32'd14);
    runOp("div_by_zero", 32'd5, 32'd0, 1'b1, 1'b0);
    checkHiLo("div_by_zero_const", 32'd5, 32'hFFFF_FFFF);
    runOp("mul_zero", 32'h0, 32'h1234_5678, 1'b0, 1'b0);

    // Random operations; IsSigned is randomised too (ignored without the option)
    for (int i = 0; i < 24; i++) begin
      a = $urandom();
      case ($urandom_range(0, 3))
        0:       b = 32'h0;
        1:       b = $urandom_range(1, 255);
        default: b = $urandom();
      endcase
      if ($urandom_range(0, 3) == 0) a = 32'h8000_0000;
      d = $urandom_range(0, 1);
      s = $urandom_range(0, 1);
      runOp($sformatf("rand%0d", i), a, b, d, s);
    end

    // HI/LO read while busy stays stalled through COMMIT
    a = 32'hDEAD_BEEF; b = 32'd13;
    expA = refResult(a, b, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, a, b, 2'b00, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 2'b00, 1'b0);
    repeat (3) tick();
    LHRead = 2'b01; #1;
    checkOutput("read_stall", Stall, 1'b1);
    cnt = 3; doneCount = 0;
    while (Stall === 1'b1 && cnt < 200) begin
      tick();
      cnt++;
      if (Done === 1'b1) doneCount++;
    end
    checkOutput("read_stall_release", cnt, W + 1);
    checkOutput("read_done_pulses", doneCount, 1);
    checkOutput("read_first_data", LHData, expA[31:0]);
    LHRead = 2'b00;

    // Second Start during RUN waits until the IDLE cycle after Done
    a = 32'h0001_0003; b = 32'h0000_0101;
    expA = refResult(a, b, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, a, b, 2'b00, 1'b0);
    tick();
    Start = 1'b0;
    repeat (2) tick();
    a = 32'd1000; b = 32'd33;
    expB = refResult(a, b, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, a, b, 2'b00, 1'b0);
    #1;
    checkOutput("start2_stall", Stall, 1'b1);
    cnt = 2;
    do begin
      tick();
      cnt++;
    end while (Done !== 1'b1 && cnt < 200);
    checkOutput("start2_first_done", cnt, W);
    checkOutput("start2_stall_at_done", Stall, 1'b1);
    tick();
    checkOutput("start2_idle_gap", {Busy, Stall}, 2'b00);
    checkHiLo("start2_first", expA[63:32], expA[31:0]);
    tick();
    checkOutput("start2_accepted", Busy, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 2'b00, 1'b0);
    finishOp("start2_second", expB, W - 1 + 1 - 1 + 1);

    // Flush at counter 10 leaves HI/LO = 0x11/0x22 intact
    runOp("seed_11_22", 32'h451, 32'h20, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'hFFFF_0000, 32'h0000_FFFF, 2'b00, 1'b0);
    tick();
    Start = 1'b0;
    repeat (10) tick();
    Flush = 1'b1; #1;
    checkOutput("flush_no_done", Done, 1'b0);
    tick();
    Flush = 1'b0;
    checkOutput("flush_busy_drop", Busy, 1'b0);
    doneCount = 0;
    repeat (W + 4) begin
      tick();
      if (Done === 1'b1) doneCount++;
    end
    checkOutput("flush_never_done", doneCount, 0);
    checkHiLo("flush_keep", 32'h11, 32'h22);

    // Flush together with Start in IDLE: ignored
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd7, 32'd9, 2'b00, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 2'b00, 1'b0);
    checkOutput("flush_start_ignored", Busy, 1'b0);

    // Flush during COMMIT: commit still completes
    a = 32'd123_456; b = 32'd789;
    expA = refResult(a, b, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, a, b, 2'b00, 1'b0);
    tick();
    Start = 1'b0;
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (Done !== 1'b1 && cnt < 200);
    checkOutput("flush_commit_done", Done, 1'b1);
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    checkOutput("flush_commit_idle", Busy, 1'b0);
    checkHiLo("flush_commit", expA[63:32], expA[31:0]);

    // Asynchronous reset at counter 20
    applyStimulus(1'b1, 1'b0, 1'b0, 32'hABCD_1234, 32'h5678_9ABC, 2'b00, 1'b0);
    tick();
    Start = 1'b0;
    repeat (20) tick();
    checkOutput("pre_reset_busy", Busy, 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_ctrl", {Busy, Stall, Done}, 3'b000);
    checkHiLo("async_reset", '0, '0);
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("after_reset_idle", Busy, 1'b0);

`ifdef MULDIV_SIGNED_EN
    runOp("smul_m3_5", 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b1);
    checkHiLo("smul_m3_5_const", 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    runOp("sdiv_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1);
    checkHiLo("sdiv_m7_2_const", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    runOp("sdiv_zero", 32'hFFFF_FFF9, 32'd0, 1'b1, 1'b1);
    checkHiLo("sdiv_zero_const", 32'hFFFF_FFF9, 32'hFFFF_FFFF);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
